uart_frame_parser: RTL
======================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameters SHALL be one per line:
- HEADER, 8'hA5, frame start byte
- MAX_LEN, 8, maximum payload bytes, range 1..15
- TIMEOUT_CYC, 50000, inter-byte timeout in clk cycles
REQ-002 Ports SHALL be one per line:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_int  in  1  high while a UART byte is being received; falling edge = byte complete
- rx_data  in  8  received byte, stable from the rx_int falling edge onward
- rd_addr  in  4  payload buffer read index
- rd_data  out  8  payload byte at rd_addr, combinational
- cmd  out  8  command byte of last good frame
- len  out  4  payload length of last good frame
- frame_ok  out  1  one-cycle pulse, good frame
- frame_err  out  1  one-cycle pulse, frame discarded
- err_code  out  2  01 length, 10 checksum, 11 timeout; held until next frame_ok/frame_err
- busy  out  1  high in any state other than IDLE
REQ-003 The block SHALL use one clock (clk) with asynchronous, active-low reset (rst_n).

Function
REQ-004 rx_int SHALL be registered once (rx_int_d); byte strobe = rx_int_d & ~rx_int; rx_data sampled in the strobe cycle.
REQ-005 The FSM SHALL have states IDLE, CMD, LEN, PAYLOAD, CSUM, each advanced only on a byte strobe.
REQ-006 IDLE: a byte equal to HEADER -> CMD; any other byte is ignored.
REQ-007 CMD: store byte in cmd shadow register, checksum = byte -> LEN.
REQ-008 LEN: byte > MAX_LEN -> frame_err, err_code=01, IDLE; byte == 0 -> CSUM; else -> PAYLOAD, index = 0; in all cases checksum += byte.
REQ-009 PAYLOAD: write byte to buffer[index], checksum += byte, index += 1; index == len-1 -> CSUM.
REQ-010 Checksum SHALL be an 8-bit sum modulo 256 of cmd, len and payload bytes; header is excluded.
REQ-011 CSUM: byte == checksum -> frame_ok, cmd/len outputs updated from shadow in the same cycle; mismatch -> frame_err, err_code=10; either -> IDLE.
REQ-012 frame_ok/frame_err SHALL assert the cycle after the final strobe (latency 1) and never together.
REQ-013 A HEADER-valued byte outside IDLE SHALL be treated as data; no resynchronisation.
REQ-014 The buffer SHALL be written only in PAYLOAD; bytes of a discarded frame remain, and cmd/len outputs keep the last good frame.
REQ-015 rd_addr >= MAX_LEN SHALL return 8'h00.

Reset
REQ-016 On rst_n low: FSM IDLE; cmd, len, checksum, index, err_code = 0; frame_ok, frame_err, busy = 0; rx_int_d = 0; buffer cleared.
REQ-017 Reset mid-frame SHALL abort the frame with no frame_err pulse.

Configuration
REQ-018 With UART_FRAME_TIMEOUT_EN defined: a counter clears on each strobe and counts while busy; reaching TIMEOUT_CYC -> frame_err, err_code=11, IDLE.
REQ-019 Without UART_FRAME_TIMEOUT_EN: no counter is built, a partial frame waits indefinitely, and err_code 11 is never produced.

Structure
REQ-020 Package uart_pkg SHALL hold FSM state encoding, the ERR_LEN/ERR_CSUM/ERR_TMO constants and the default HEADER.
REQ-021 The timeout counter SHALL be one sub-module, uart_frame_timeout, instantiated only under UART_FRAME_TIMEOUT_EN.

Verification
REQ-022 Bytes A5 10 02 01 02 15 -> frame_ok, cmd=0x10, len=2, rd_data[0]=0x01, rd_data[1]=0x02.
REQ-023 Bytes A5 20 00 20 -> frame_ok, len=0; cmd=0x20.
REQ-024 Bytes A5 10 02 01 02 16 -> frame_err, err_code=10; cmd/len unchanged from the prior good frame.
REQ-025 Bytes A5 10 09 -> frame_err, err_code=01 after the third byte; a following good frame is accepted.
REQ-026 With the macro, TIMEOUT_CYC=100: bytes A5 10 then idle 100 cycles -> frame_err, err_code=11, busy=0.
REQ-027 Reset asserted after A5 10 02 01 -> no pulse; busy=0; a good frame after release -> frame_ok.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding,
// error codes and the default frame start byte.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the UART frame parser. Cleared on every
// byte strobe and while the parser is idle; flags expiry after TIMEOUT_CYC
// cycles without a byte while a frame is in progress.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Expiry is reported one cycle early so the registered frame_err lands
  // exactly TIMEOUT_CYC cycles after the last byte.
  assign expired = run && !clear && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter, restarted by each byte and held at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: HEADER, CMD, LEN, PAYLOAD[LEN], CSUM.
// Checksum is the 8-bit sum of CMD, LEN and payload bytes.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_int,
  input  logic [7:0] rx_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] cmd,
  output logic [3:0] len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  state_t     state, state_d;
  logic       rx_int_d;
  logic       strobe;
  logic       tmo_hit;
  logic       wr_en;
  logic [7:0] csum, csum_d;
  logic [3:0] idx, idx_d;
  logic [7:0] cmd_sh, cmd_sh_d;
  logic [3:0] len_sh, len_sh_d;
  logic [7:0] cmd_d;
  logic [3:0] len_d;
  logic       ok_d, err_d;
  logic [1:0] err_code_d;
  logic [7:0] pay_buf [MAX_LEN];

  assign strobe = rx_int_d & ~rx_int;
  assign busy   = (state != ST_IDLE);

`ifdef UART_FRAME_TIMEOUT_EN
  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (strobe),
    .run     (busy),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // Byte-complete edge detector on the receiver interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_int_d <= 1'b0;
    end else begin
      rx_int_d <= rx_int;
    end
  end

  // Next-state and datapath decode; everything advances only on a strobe.
  always_comb begin
    state_d    = state;
    csum_d     = csum;
    idx_d      = idx;
    cmd_sh_d   = cmd_sh;
    len_sh_d   = len_sh;
    cmd_d      = cmd;
    len_d      = len;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code;
    wr_en      = 1'b0;
    if (strobe) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == HEADER) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_sh_d = rx_data;
          csum_d   = rx_data;
          state_d  = ST_LEN;
        end
        ST_LEN: begin
          csum_d = csum + rx_data;
          if (rx_data > 8'(MAX_LEN)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else if (rx_data == 8'h00) begin
            len_sh_d = '0;
            state_d  = ST_CSUM;
          end else begin
            len_sh_d = rx_data[3:0];
            idx_d    = '0;
            state_d  = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_en  = 1'b1;
          csum_d = csum + rx_data;
          idx_d  = idx + 4'd1;
          if (idx == len_sh - 4'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == csum) begin
            ok_d       = 1'b1;
            cmd_d      = cmd_sh;
            len_d      = len_sh;
            err_code_d = ERR_NONE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = ST_IDLE;
    end
  end

  // FSM and frame registers; result pulses land one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      csum      <= '0;
      idx       <= '0;
      cmd_sh    <= '0;
      len_sh    <= '0;
      cmd       <= '0;
      len       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_d;
      csum      <= csum_d;
      idx       <= idx_d;
      cmd_sh    <= cmd_sh_d;
      len_sh    <= len_sh_d;
      cmd       <= cmd_d;
      len       <= len_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= err_code_d;
    end
  end

  // Payload buffer; decoded per entry so a 4-bit index fits any MAX_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) pay_buf[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (idx == 4'(i)) pay_buf[i] <= rx_data;
      end
    end
  end

  // Combinational read port; addresses beyond the buffer read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (rd_addr == 4'(i)) rd_data = pay_buf[i];
    end
  end

endmodule
